// File: rtl/gate_bist.sv
// N-input universal gate with registered output and an exhaustive self-test sweep.
// Latency 1 cycle; start is honoured only in IDLE, and mode/a are ignored while busy.
module gate_bist #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   mode,
    input  logic [N-1:0] a,
    input  logic         start,
    input  logic         inject,
    output logic         y,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_cnt
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam logic [N-1:0] VEC_ONE = 1;
    localparam logic [N:0]   ERR_ONE = 1;

    state_t       state, state_nxt;
    logic [N-1:0] vec_cnt;
    logic [2:0]   mode_lat;
    logic [N-1:0] vec;
    logic [2:0]   mode_eff;
    logic         core_out;
    logic         ref_bit;
    logic         ref_d;
    logic         ref_par;
    logic         last_vec;

    assign vec      = (state == SWEEP) ? vec_cnt : a;
    assign mode_eff = (state == SWEEP) ? mode_lat : mode;
    assign last_vec = (vec_cnt == {N{1'b1}});

    always_comb begin
        core_out = 1'b0;
        case (mode_eff)
            3'b000:  core_out = &vec;
            3'b001:  core_out = ~&vec;
            3'b010:  core_out = |vec;
            3'b011:  core_out = ~|vec;
            3'b100:  core_out = ^vec;
            3'b101:  core_out = ~^vec;
            3'b110:  core_out = vec[0];
            default: core_out = ~vec[0];
        endcase
    end

    // Reference is built from comparisons and a bit loop, not the core's reduction operators.
    always_comb begin
        ref_par = 1'b0;
        for (int i = 0; i < N; i++) begin
            ref_par = ref_par ^ vec_cnt[i];
        end
        ref_bit = 1'b0;
        case (mode_lat)
            3'b000:  ref_bit = (vec_cnt == {N{1'b1}});
            3'b001:  ref_bit = (vec_cnt != {N{1'b1}});
            3'b010:  ref_bit = (vec_cnt != '0);
            3'b011:  ref_bit = (vec_cnt == '0);
            3'b100:  ref_bit = ref_par;
            3'b101:  ref_bit = !ref_par;
            3'b110:  ref_bit = (vec_cnt[0] == 1'b1);
            default: ref_bit = (vec_cnt[0] == 1'b0);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (last_vec) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            default: if (!start) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SWEEP) || (state == DRAIN);
        done = (state == DONE);
        pass = (state == DONE) && (err_cnt == '0);
    end

    // The first SWEEP cycle has no result in y yet, so comparison starts at vec_cnt 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= 1'b0;
            ref_d    <= 1'b0;
            vec_cnt  <= '0;
            mode_lat <= 3'b000;
            err_cnt  <= '0;
        end else begin
            y     <= core_out ^ inject;
            ref_d <= ref_bit;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_lat <= mode;
                        err_cnt  <= '0;
                        vec_cnt  <= '0;
                    end
                end
                SWEEP: begin
                    vec_cnt <= vec_cnt + VEC_ONE;
                    if ((vec_cnt != '0) && (y != ref_d)) err_cnt <= err_cnt + ERR_ONE;
                end
                DRAIN: begin
                    if (y != ref_d) err_cnt <= err_cnt + ERR_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Directed bench for gate_bist: vector table for the combinational path, sequences for BIST runs.
module tb_gate_bist;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode;
    logic [7:0] a;
    logic       start;
    logic       inject;

    logic       y2, busy2, done2, pass2;
    logic [2:0] err2;
    logic       y3, busy3, done3, pass3;
    logic [3:0] err3;
    logic       y4, busy4, done4, pass4;
    logic [4:0] err4;

    int tests = 0;
    int fails = 0;

    gate_bist #(.N(2)) u2 (.clk(clk), .rst_n(rst_n), .mode(mode), .a(a[1:0]), .start(start),
        .inject(inject), .y(y2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2));
    gate_bist #(.N(3)) u3 (.clk(clk), .rst_n(rst_n), .mode(mode), .a(a[2:0]), .start(start),
        .inject(inject), .y(y3), .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3));
    gate_bist #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .mode(mode), .a(a[3:0]), .start(start),
        .inject(inject), .y(y4), .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [2:0] mode;
        logic [7:0] a;
        logic       y;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic get(input int n, output logic yy, output logic bb, output logic dd,
                       output logic pp, output logic [8:0] ee);
        case (n)
            2:       begin yy = y2; bb = busy2; dd = done2; pp = pass2; ee = {6'b0, err2}; end
            3:       begin yy = y3; bb = busy3; dd = done3; pp = pass3; ee = {5'b0, err3}; end
            default: begin yy = y4; bb = busy4; dd = done4; pp = pass4; ee = {4'b0, err4}; end
        endcase
    endtask

    task automatic chk_zero(input int n, input string tag);
        logic yy, bb, dd, pp;
        logic [8:0] ee;
        get(n, yy, bb, dd, pp, ee);
        chk({tag, "_y"}, {8'b0, yy}, 9'd0);
        chk({tag, "_busy"}, {8'b0, bb}, 9'd0);
        chk({tag, "_done"}, {8'b0, dd}, 9'd0);
        chk({tag, "_pass"}, {8'b0, pp}, 9'd0);
        chk({tag, "_err"}, ee, 9'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        start  = 1'b0;
        inject = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // inj: -1 never, -2 every cycle, k>=0 only during busy cycle k+1.
    task automatic run_bist(input int n, input int inj, input bit meddle,
                            output int bcnt, output logic [8:0] ee, output logic pp,
                            output logic [15:0] ysw);
        logic yy, bb, dd;
        bit   fin;
        bcnt = 0;
        ysw  = '0;
        fin  = 0;
        start  = 1'b1;
        inject = (inj == -2);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            get(n, yy, bb, dd, pp, ee);
            if (dd) begin
                fin = 1;
                break;
            end
            if (bb) bcnt++;
            if (i < 16) ysw[i] = yy;
            if (i == 0) start = 1'b0;
            if (meddle && i == 1) begin
                mode  = 3'b000;
                a     = 8'h00;
                start = 1'b1;
            end
            if (meddle && i == 2) start = 1'b0;
            if (inj >= 0) inject = (i == inj);
        end
        inject = 1'b0;
        if (!fin) chk("bist_timeout", 9'd0, 9'd1);
    endtask

    initial begin
        int          bcnt;
        logic [8:0]  ee;
        logic        pp, yy, bb, dd;
        logic [15:0] ysw;

        tbl[0]  = '{2, 3'b001, 8'h0, 1'b1};
        tbl[1]  = '{2, 3'b001, 8'h1, 1'b1};
        tbl[2]  = '{2, 3'b001, 8'h2, 1'b1};
        tbl[3]  = '{2, 3'b001, 8'h3, 1'b0};
        tbl[4]  = '{2, 3'b000, 8'h0, 1'b0};
        tbl[5]  = '{2, 3'b000, 8'h1, 1'b0};
        tbl[6]  = '{2, 3'b000, 8'h2, 1'b0};
        tbl[7]  = '{2, 3'b000, 8'h3, 1'b1};
        tbl[8]  = '{4, 3'b100, 8'hB, 1'b1};
        tbl[9]  = '{4, 3'b100, 8'hF, 1'b0};
        tbl[10] = '{4, 3'b111, 8'h6, 1'b1};
        tbl[11] = '{4, 3'b010, 8'h0, 1'b0};
        tbl[12] = '{4, 3'b011, 8'h0, 1'b1};
        tbl[13] = '{4, 3'b101, 8'hB, 1'b0};
        tbl[14] = '{4, 3'b110, 8'h1, 1'b1};
        tbl[15] = '{4, 3'b000, 8'hF, 1'b1};
        tbl[16] = '{4, 3'b001, 8'hF, 1'b0};
        tbl[17] = '{3, 3'b011, 8'h4, 1'b0};

        rst_n  = 1'b0;
        mode   = 3'b000;
        a      = 8'h00;
        start  = 1'b0;
        inject = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero(2, "rst_n2");
        chk_zero(3, "rst_n3");
        chk_zero(4, "rst_n4");
        rst_n = 1'b1;

        // Each vector held two cycles; result must appear after the first edge and stay.
        for (int i = 0; i < 18; i++) begin
            mode = tbl[i].mode;
            a    = tbl[i].a;
            for (int h = 0; h < 2; h++) begin
                @(negedge clk);
                get(tbl[i].n, yy, bb, dd, pp, ee);
                chk($sformatf("vec%0d_h%0d", i, h), {8'b0, yy}, {8'b0, tbl[i].y});
            end
        end

        // N=2 NAND clean run
        do_reset();
        mode = 3'b001;
        run_bist(2, -1, 0, bcnt, ee, pp, ysw);
        chk("t3_busy_cycles", 9'(bcnt), 9'd5);
        chk("t3_pass", {8'b0, pp}, 9'd1);
        chk("t3_err", ee, 9'd0);
        @(negedge clk);
        get(2, yy, bb, dd, pp, ee);
        chk("t3_idle_done", {8'b0, dd}, 9'd0);
        chk("t3_idle_busy", {8'b0, bb}, 9'd0);

        // N=3 OR with inject held throughout, then a single injected cycle
        do_reset();
        mode = 3'b010;
        run_bist(3, -2, 0, bcnt, ee, pp, ysw);
        chk("t4_busy_cycles", 9'(bcnt), 9'd9);
        chk("t4_pass", {8'b0, pp}, 9'd0);
        chk("t4_err_all", ee, 9'd8);
        @(negedge clk);
        run_bist(3, 2, 0, bcnt, ee, pp, ysw);
        chk("t4_one_busy", 9'(bcnt), 9'd9);
        chk("t4_err_one", ee, 9'd1);
        chk("t4_one_pass", {8'b0, pp}, 9'd0);
        repeat (3) @(negedge clk);
        get(3, yy, bb, dd, pp, ee);
        chk("t4_err_hold_idle", ee, 9'd1);
        chk("t4_pass_idle", {8'b0, pp}, 9'd0);

        // N=2: mode/a/start disturbed mid-run; NAND sweep outputs must persist
        do_reset();
        mode = 3'b001;
        a    = 8'h03;
        run_bist(2, -1, 1, bcnt, ee, pp, ysw);
        chk("t5_busy_cycles", 9'(bcnt), 9'd5);
        chk("t5_err", ee, 9'd0);
        chk("t5_pass", {8'b0, pp}, 9'd1);
        chk("t5_sweep_y", {5'b0, ysw[4:1]}, {5'b0, 4'b0111});
        repeat (3) @(negedge clk);
        get(2, yy, bb, dd, pp, ee);
        chk("t5_no_restart_busy", {8'b0, bb}, 9'd0);
        chk("t5_no_restart_done", {8'b0, dd}, 9'd0);
        chk("t5_idle_y_and", {8'b0, yy}, 9'd0);

        // N=4: asynchronous reset in the 5th SWEEP cycle
        do_reset();
        mode  = 3'b001;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        get(4, yy, bb, dd, pp, ee);
        chk("t6_busy_before", {8'b0, bb}, 9'd1);
        chk("t6_y_before", {8'b0, yy}, 9'd1);
        rst_n = 1'b0;
        #1;
        chk_zero(4, "t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_bist(4, -1, 0, bcnt, ee, pp, ysw);
        chk("t6_busy_cycles", 9'(bcnt), 9'd17);
        chk("t6_pass", {8'b0, pp}, 9'd1);
        chk("t6_err", ee, 9'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Parametrised N-input universal logic gate with a registered output and a built-in self-test (BIST) sequencer.
- In normal operation it computes one of eight logic functions on an N-bit input vector.
- On request, it sweeps all 2^N input combinations through the gate core, compares each result against an independent reference model, and reports the error count and a pass/fail result.
- It replaces the fixed 2-input gate cells and their hand-written exhaustive sweeps in the gate library.

Parameters:
- N, 2, number of gate inputs; legal range 2..8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  3  function select: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 BUF a[0], 111 NOT a[0].
- a  input  N  operand vector in normal operation.
- start  input  1  BIST request; sampled in IDLE only.
- inject  input  1  fault injection; when 1, the core output is inverted before the output register (used for verification of the checker).
- y  output  1  registered gate result.
- busy  output  1  high while BIST is in SWEEP or DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1; 1 iff err_cnt==0.
- err_cnt  output  N+1  number of mismatches in the last BIST run.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): y=0, busy=0, done=0, pass=0, err_cnt=0, state=IDLE, sweep vector=0, latched mode=000.
- Core:
  - Combinational f(mode_eff, vec), optionally inverted by inject, then registered into y.
  - Latency is 1 cycle.
  - Reductions span all N bits. BUF/NOT use bit 0 only.
- Operand mux:
  - Outside SWEEP: vec=a and mode_eff=mode.
  - In SWEEP: vec=sweep counter and mode_eff=latched mode.
- State IDLE:
  - busy=0, done=0.
  - On start=1: latch mode, clear err_cnt, set the sweep counter to 0, go to SWEEP.
- State SWEEP:
  - busy=1. Each cycle, apply counter value v to the core.
  - The reference value ref(v) is computed by a separate case statement, not shared with the core, and is pipelined 1 stage alongside y.
  - From the second SWEEP cycle on, compare y against the delayed reference. On mismatch, err_cnt increments.
  - The counter increments modulo 2^N.
  - After the cycle that applies v=2^N-1, go to DRAIN.
  - SWEEP lasts exactly 2^N cycles.
- State DRAIN:
  - busy=1. Performs the final comparison for v=2^N-1.
  - Next state is DONE.
- State DONE:
  - done=1, busy=0, pass=(err_cnt==0).
  - Holds until start=0, then returns to IDLE.
  - If start stays high, the block remains in DONE; a new run needs a 0→1 cycle through IDLE.
- err_cnt:
  - Maximum value is 2^N, which fits in N+1 bits, so no saturation is needed.
  - Holds its value through IDLE until the next start.
- Timing: busy rises on the edge after start is sampled. done rises 2^N+1 cycles after busy rises.
- Input handling during BIST:
  - start while busy=1 is ignored.
  - Changes to mode and a during BIST are ignored.
  - inject stays live during BIST; its per-cycle value affects that cycle's comparison.
- Reset mid-SWEEP aborts the run; all outputs are as at reset.
- After DONE, y reflects the normal path again from the first IDLE cycle plus 1 cycle of latency.

Test Plan:
1. N=2, mode=001, a=00,01,10,11, each held 2 cycles → y=1,1,1,0, each appearing one cycle after the input is applied. Repeat with mode=000 → y=0,0,0,1.
2. N=4, mode=100, a=1011 → y=1. Change to a=1111 → y=0 on the next edge. mode=111, a=xxx0 → y=1.
3. N=2, mode=001, pulse start, inject=0 → busy high for 5 cycles, then done=1, pass=1, err_cnt=0. Drop start → IDLE, done=0.
4. N=3, mode=010, start with inject=1 held throughout → done=1 after 9 busy cycles, pass=0, err_cnt=8. Then inject high for exactly one SWEEP cycle only → err_cnt=1.
5. N=2, change mode and a, and pulse start again, while busy=1 → run completes with the originally latched mode, err_cnt=0, no restart.
6. N=4, assert rst_n=0 in the 5th SWEEP cycle → y, busy, done, pass and err_cnt are all 0 immediately (asynchronous). After release, a new start runs the full 16+1 busy cycles and passes.
